// File: rtl/tx_serializer_pkg.sv
// tx_serializer_pkg: shared FSM encoding, word geometry and sizing helper for tx_word_serializer.
package tx_serializer_pkg;

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] LOAD      = 2'd1;
    localparam logic [1:0] START     = 2'd2;
    localparam logic [1:0] WAIT_DONE = 2'd3;

    localparam int DEFAULT_WORD_W = 32;
    localparam int BYTES_PER_WORD = DEFAULT_WORD_W / 8;

    function automatic int byte_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tx_word_fifo.sv
// tx_word_fifo: synchronous word FIFO; a push alongside a pop is honoured even when full.
module tx_word_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          do_push, do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge CLK or negedge RST)
        if (!RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= do_push ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr <= do_pop ? rd_ptr + 1'b1 : rd_ptr;
            count  <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end

    always_ff @(posedge CLK)
        if (do_push) mem[wr_ptr] <= din;

endmodule

// File: rtl/tx_word_serializer.sv
// tx_word_serializer: buffers result words and feeds them MSB-first, one byte per TX_Start/TX_Done handshake.
// Define TX_CHECKSUM_EN to append an XOR checksum byte after each word.
module tx_word_serializer
    import tx_serializer_pkg::*;
#(
    parameter int WORD_W     = DEFAULT_WORD_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              WORD_VALID,
    input  logic [WORD_W-1:0] WORD_IN,
    output logic              WORD_READY,
    input  logic              TX_Done,
    output logic              TX_Start,
    output logic [7:0]        DATAOUT,
    output logic              BUSY,
    output logic              OVERFLOW
);

    localparam int BPW = WORD_W / 8;
`ifdef TX_CHECKSUM_EN
    localparam int LAST = BPW;
`else
    localparam int LAST = BPW - 1;
`endif
    localparam int IW = byte_idx_w(BPW + 1);

    logic [1:0]        state;
    logic [WORD_W-1:0] shreg, fifo_dout;
    logic [IW-1:0]     byte_idx;
    logic              full, empty, overflow;
`ifdef TX_CHECKSUM_EN
    logic [7:0]        csum;
`endif

    tx_word_fifo #(.W(WORD_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .CLK   (CLK),
        .RST   (RST),
        .push  (WORD_VALID && !full),
        .pop   (state == LOAD),
        .din   (WORD_IN),
        .dout  (fifo_dout),
        .full  (full),
        .empty (empty)
    );

    // The outgoing byte is always the top of the shift register, so it is stable through WAIT_DONE.
    assign DATAOUT    = shreg[WORD_W-1 -: 8];
    assign TX_Start   = state == START;
    assign BUSY       = (state != IDLE) || !empty;
    assign WORD_READY = !full;
    assign OVERFLOW   = overflow;

    always_ff @(posedge CLK or negedge RST)
        if (!RST) begin
            state    <= IDLE;
            shreg    <= '0;
            byte_idx <= '0;
            overflow <= 1'b0;
`ifdef TX_CHECKSUM_EN
            csum     <= 8'h00;
`endif
        end else begin
            if (WORD_VALID && full) overflow <= 1'b1;
            if (state == IDLE) begin
                if (!empty) state <= LOAD;
            end else if (state == LOAD) begin
                shreg    <= fifo_dout;
                byte_idx <= '0;
                state    <= START;
`ifdef TX_CHECKSUM_EN
                csum     <= 8'h00;
`endif
            end else if (state == START) begin
                state <= WAIT_DONE;
            end else if (TX_Done) begin
                byte_idx <= byte_idx + 1'b1;
                state    <= (byte_idx == IW'(LAST)) ? IDLE : START;
`ifdef TX_CHECKSUM_EN
                // After the last data byte the checksum is parked at the top of the register.
                csum  <= csum ^ DATAOUT;
                shreg <= (byte_idx == IW'(BPW - 1)) ? WORD_W'(csum ^ DATAOUT) << (WORD_W - 8) : shreg << 8;
`else
                shreg <= shreg << 8;
`endif
            end
        end

endmodule

// File: tb/tb_tx_word_serializer.sv
// tb_tx_word_serializer: randomized self-checking bench with a byte-stream scoreboard and a transmitter model.
module tb_tx_word_serializer;

`ifdef TX_CHECKSUM_EN
    localparam int BPB = 5;
`else
    localparam int BPB = 4;
`endif

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        WORD_VALID = 1'b0;
    logic [31:0] WORD_IN = '0;
    logic        WORD_READY, TX_Start, BUSY, OVERFLOW;
    logic [7:0]  DATAOUT;
    logic        done_model = 1'b0;
    logic        done_inj = 1'b0;
    logic        TX_Done;

    assign TX_Done = done_model | done_inj;

    tx_word_serializer #(.WORD_W(32), .FIFO_DEPTH(4)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .WORD_VALID (WORD_VALID),
        .WORD_IN    (WORD_IN),
        .WORD_READY (WORD_READY),
        .TX_Done    (TX_Done),
        .TX_Start   (TX_Start),
        .DATAOUT    (DATAOUT),
        .BUSY       (BUSY),
        .OVERFLOW   (OVERFLOW)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int failures = 0;
    logic [7:0]  got[$];
    logic [7:0]  exp_q[$];
    logic [31:0] wq[$];
    int   ndone = 0;
    int   done_base = 0;
    int   delay = 10;
    bit   stall = 1'b0;
    int   stable_err = 0;
    int   start_err = 0;
    logic busy_at_done = 1'b0;
    logic busy_after = 1'b1;
    logic [7:0] m_cur;
    int   m_n;
    bit   m_abort;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        if (obs !== want) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, obs, want);
        end
    endtask

    // Transmitter: captures each requested byte, holds it for `delay` cycles (or while stalled), then pulses TX_Done.
    initial begin
        forever begin
            @(negedge CLK);
            if (done_model) begin
                done_model = 1'b0;
                ndone++;
                busy_after = BUSY;
            end
            if (TX_Start === 1'b1 && RST === 1'b1) begin
                m_cur = DATAOUT;
                got.push_back(m_cur);
                m_n = 0;
                m_abort = 1'b0;
                while ((m_n < delay || stall) && !m_abort) begin
                    @(negedge CLK);
                    m_n++;
                    if (RST !== 1'b1) m_abort = 1'b1;
                    else begin
                        if (DATAOUT !== m_cur) stable_err++;
                        if (TX_Start !== 1'b0) start_err++;
                    end
                end
                if (!m_abort) begin
                    done_model = 1'b1;
                    busy_at_done = BUSY;
                end
            end
        end
    end

    function automatic void add_exp(input logic [31:0] w);
        logic [7:0] cs = 8'h00;
        logic [7:0] b;
        for (int i = 0; i < 4; i++) begin
            b = 8'(w >> (8 * (3 - i)));
            cs ^= b;
            exp_q.push_back(b);
        end
`ifdef TX_CHECKSUM_EN
        exp_q.push_back(cs);
`endif
    endfunction

    task automatic clear_streams();
        got.delete();
        exp_q.delete();
        done_base = ndone;
    endtask

    task automatic push_burst(input string tag);
        for (int i = 0; i < wq.size(); i++) begin
            @(negedge CLK);
            check($sformatf("%s_ready%0d", tag, i), WORD_READY, 1'b1);
            WORD_VALID = 1'b1;
            WORD_IN = wq[i];
            add_exp(wq[i]);
        end
        @(negedge CLK);
        WORD_VALID = 1'b0;
    endtask

    task automatic drain(input string tag, input int n);
        int t = 0;
        while ((got.size() < n || ndone - done_base < n) && t < 2000) begin
            @(negedge CLK);
            t++;
        end
        check({tag, "_drain"}, 32'(got.size()), 32'(n));
    endtask

    task automatic compare_stream(input string tag);
        check({tag, "_nbytes"}, 32'(got.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            check($sformatf("%s_byte%0d", tag, i), got[i], exp_q[i]);
    endtask

    initial begin
        bit saw;
        int t;
        repeat (3) @(negedge CLK);
        check("rst_start", TX_Start, 1'b0);
        check("rst_data", DATAOUT, 8'h00);
        check("rst_busy", BUSY, 1'b0);
        check("rst_ovf", OVERFLOW, 1'b0);
        check("rst_ready", WORD_READY, 1'b1);
        RST = 1'b1;
        @(negedge CLK);
        check("idle_busy", BUSY, 1'b0);

        // single word, 10-cycle transmitter
        clear_streams();
        wq = '{32'h12345678};
        push_burst("w1");
        check("lat_e0", TX_Start, 1'b0);
        @(negedge CLK);
        check("lat_e1", TX_Start, 1'b0);
        @(negedge CLK);
        check("lat_e2", TX_Start, 1'b1);
        drain("w1", BPB);
        compare_stream("w1");
        check("w1_busy_at_done", busy_at_done, 1'b1);
        check("w1_busy_after", busy_after, 1'b0);

        // stray TX_Done in IDLE
        repeat (2) @(negedge CLK);
        t = got.size();
        done_inj = 1'b1;
        @(negedge CLK);
        done_inj = 1'b0;
        saw = 1'b0;
        repeat (4) begin
            @(negedge CLK);
            if (TX_Start !== 1'b0 || BUSY !== 1'b0) saw = 1'b1;
        end
        check("stray_activity", saw, 1'b0);
        check("stray_bytes", 32'(got.size()), 32'(t));

        // five words with the transmitter stalled, then a rejected sixth
        clear_streams();
        stall = 1'b1;
        delay = 3;
        wq = '{32'hA1B2C3D4, 32'h11223344, 32'h55667788, 32'h99AABBCC, 32'hDDEEFF00};
        push_burst("st");
        check("st_ready_full", WORD_READY, 1'b0);
        WORD_VALID = 1'b1;
        WORD_IN = 32'hBAD0BAD0;
        @(negedge CLK);
        check("st_ovf", OVERFLOW, 1'b1);
        WORD_VALID = 1'b0;
        check("st_one_started", 32'(got.size()), 32'd1);
        stall = 1'b0;
        drain("st", 5 * BPB);
        compare_stream("st");
        check("st_ovf_sticky", OVERFLOW, 1'b1);

        // random bursts with random transmitter latency
        for (int r = 0; r < 4; r++) begin
            clear_streams();
            delay = $urandom_range(1, 6);
            wq.delete();
            for (int k = 0; k < $urandom_range(1, 3); k++) wq.push_back($urandom);
            push_burst($sformatf("rnd%0d", r));
            drain($sformatf("rnd%0d", r), wq.size() * BPB);
            compare_stream($sformatf("rnd%0d", r));
        end

        // reset asserted while the second byte is outstanding
        clear_streams();
        delay = 10;
        wq = '{32'hDEADBEEF};
        push_burst("ab");
        t = 0;
        while (got.size() < 2 && t < 500) begin
            @(negedge CLK);
            t++;
        end
        check("ab_reach_byte2", 32'(got.size()), 32'd2);
        repeat (3) @(negedge CLK);
        #2 RST = 1'b0;
        #1;
        check("ab_start", TX_Start, 1'b0);
        check("ab_data", DATAOUT, 8'h00);
        check("ab_busy", BUSY, 1'b0);
        check("ab_ovf", OVERFLOW, 1'b0);
        check("ab_ready", WORD_READY, 1'b1);
        repeat (3) @(negedge CLK);
        clear_streams();
        RST = 1'b1;
        delay = 4;
        wq = '{32'hA5A50F0F};
        push_burst("pr");
        drain("pr", BPB);
        repeat (20) @(negedge CLK);
        compare_stream("pr");

        check("dataout_stable", 32'(stable_err), 32'd0);
        check("no_start_in_wait", 32'(start_err), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
